// File: rtl/lsu_ctrl_r32i.sv
// RV32I load/store sequencer: validates and aligns a decoded LOAD/STORE, runs one
// req/ack transaction on the word-wide data port, then reports Done or Fault for a cycle.
module lsu_ctrl_r32i #(
    parameter int dataW   = 32,
    parameter int MaxWait = 15
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             MemStart,
    input  logic             IsStore,
    input  logic [2:0]       Funct3,
    input  logic [dataW-1:0] EffAddr,
    input  logic [dataW-1:0] StoreData,
    output logic             Busy,
    output logic             Done,
    output logic             Fault,
    output logic [dataW-1:0] LoadData,
    output logic             MemReq,
    output logic             MemWe,
    output logic [dataW-1:0] MemAddr,
    output logic [dataW-1:0] MemWData,
    output logic [3:0]       MemByteEn,
    input  logic             MemAck,
    input  logic [dataW-1:0] MemRData
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

    state_e           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       lane_q, lane_d;
    logic [dataW-1:0] addr_q, addr_d;
    logic [dataW-1:0] wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [7:0]       wait_q, wait_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic [dataW-1:0] load_q, load_d;

    logic             legal, misaligned;
    logic [3:0]       be_new;
    logic [dataW-1:0] wdata_new;
    logic [dataW-1:0] rd_shift;
    logic [dataW-1:0] load_ext;

    // Decode of the incoming request; only consumed when MemStart is accepted in IDLE.
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        be_new     = 4'b0000;
        wdata_new  = StoreData;
        if (IsStore) begin
            legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
        end else begin
            legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b101);
        end
        case (Funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << EffAddr[1:0];
                wdata_new = {4{StoreData[7:0]}};
            end
            2'b01: begin
                misaligned = EffAddr[0];
                be_new     = EffAddr[1] ? 4'b1100 : 4'b0011;
                wdata_new  = {2{StoreData[15:0]}};
            end
            2'b10: begin
                misaligned = (EffAddr[1:0] != 2'b00);
                be_new     = 4'b1111;
                wdata_new  = StoreData;
            end
            default: begin
                be_new    = 4'b0000;
                wdata_new = StoreData;
            end
        endcase
    end

    // Halfword lanes are always even, so the same byte shift serves both widths.
    always_comb begin
        rd_shift = MemRData >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_ext = {24'b0, rd_shift[7:0]};
            3'b101:  load_ext = {16'b0, rd_shift[15:0]};
            default: load_ext = MemRData;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        lane_d     = lane_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wait_d     = wait_q;
        req_d      = req_q;
        done_d     = 1'b0;
        fault_d    = 1'b0;
        load_d     = '0;
        case (state_q)
            IDLE: begin
                if (MemStart) begin
                    is_store_d = IsStore;
                    funct3_d   = Funct3;
                    lane_d     = EffAddr[1:0];
                    addr_d     = {EffAddr[dataW-1:2], 2'b00};
                    wdata_d    = wdata_new;
                    be_d       = be_new;
                    wait_d     = 8'd0;
                    if (legal && !misaligned) begin
                        state_d = ACCESS;
                        req_d   = 1'b1;
                    end else begin
                        state_d = RESP;
                        fault_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (MemAck) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    load_d  = is_store_q ? '0 : load_ext;
                end else if (wait_q == 8'(MaxWait - 1)) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            lane_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 4'b0000;
            wait_q     <= 8'd0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            load_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            lane_q     <= lane_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wait_q     <= wait_d;
            req_q      <= req_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            load_q     <= load_d;
        end
    end

    // Port fields are forced to zero whenever no request is outstanding.
    assign Busy      = !Reset && ((state_q == IDLE && MemStart) || state_q == ACCESS);
    assign Done      = done_q;
    assign Fault     = fault_q;
    assign LoadData  = load_q;
    assign MemReq    = req_q;
    assign MemWe     = req_q && is_store_q;
    assign MemAddr   = req_q ? addr_q : '0;
    assign MemWData  = req_q ? wdata_q : '0;
    assign MemByteEn = req_q ? be_q : 4'b0000;

endmodule
